// File: rtl/ctrl_pkg.sv
// Shared types and the word decoder used by the control pipeline.
// Struct fields are sized for the widest legal configuration.
package ctrl_pkg;

    localparam int MAX_IW = 32;
    localparam int MAX_OW = 8;
    localparam int MAX_AW = 8;
    localparam int MAX_JW = 32;

    localparam logic [2:0] CLS_BR = 3'b100;
    localparam logic [2:0] CLS_ST = 3'b101;
    localparam logic [2:0] CLS_LD = 3'b110;
    localparam logic [2:0] CLS_MV = 3'b111;

    typedef enum logic [2:0] {
        CL_R, CL_HALT, CL_BR, CL_ST, CL_LD, CL_MV
    } class_e;

    typedef enum logic [1:0] {
        RUN, STALL, SQUASH, HALT
    } state_e;

    typedef struct packed {
        class_e             cls;
        logic [MAX_JW-1:0]  jptr;
        logic [MAX_OW-1:0]  aluop;
        logic [MAX_AW-1:0]  ra;
        logic [MAX_AW-1:0]  rb;
        logic [MAX_AW-1:0]  wd;
        logic               wen_r;
        logic               wen_d;
        logic               ren_d;
        logic               mem_to_reg;
        logic               jen;
        logic               done;
    } ctrl_t;

    function automatic ctrl_t decode(
        input logic [MAX_IW-1:0] instr,
        input int iw,
        input int ow,
        input int aw,
        input int jw
    );
        ctrl_t c;
        logic [MAX_IW-1:0] amask;
        logic [MAX_IW-1:0] omask;
        logic [MAX_IW-1:0] jmask;
        logic [MAX_IW-1:0] fh;
        logic [MAX_IW-1:0] fl;
        logic [2:0] cls;
        logic is_halt;
        amask = (MAX_IW'(1) << aw) - MAX_IW'(1);
        omask = (MAX_IW'(1) << ow) - MAX_IW'(1);
        // target field is zero-extended, then cut to the pointer width
        jmask = ((MAX_IW'(1) << (iw - 3)) - MAX_IW'(1))
              & ((MAX_IW'(1) << jw) - MAX_IW'(1));
        fh = (instr >> aw) & amask;
        fl = instr & amask;
        cls = 3'(instr >> (iw - 3));
        is_halt = (instr == ((MAX_IW'(1) << (iw - 1)) - MAX_IW'(1)));
        c = '0;
        unique case (1'b1)
            is_halt: begin
                c.cls  = CL_HALT;
                c.done = 1'b1;
            end
            (!cls[2] && !is_halt): begin
                c.cls   = CL_R;
                c.aluop = MAX_OW'((instr >> (iw - 1 - ow)) & omask);
                c.ra    = MAX_AW'(fh & (amask >> 1));
                c.rb    = MAX_AW'(fl);
                c.wd    = MAX_AW'(fl);
                c.wen_r = 1'b1;
            end
            (cls == CLS_BR): begin
                c.cls  = CL_BR;
                c.jen  = 1'b1;
                c.jptr = MAX_JW'(instr & jmask);
            end
            (cls == CLS_ST): begin
                c.cls   = CL_ST;
                c.wen_d = 1'b1;
                c.ra    = MAX_AW'(amask);
                c.rb    = MAX_AW'(fh);
            end
            (cls == CLS_LD): begin
                c.cls        = CL_LD;
                c.ren_d      = 1'b1;
                c.mem_to_reg = 1'b1;
                c.wen_r      = 1'b1;
                c.wd         = MAX_AW'(fh);
                c.ra         = MAX_AW'(amask - MAX_IW'(1));
            end
            (cls == CLS_MV): begin
                c.cls        = CL_MV;
                c.aluop      = MAX_OW'(omask);
                c.mem_to_reg = 1'b1;
                c.wen_r      = 1'b1;
                c.ra         = MAX_AW'(fh);
                c.wd         = MAX_AW'(fl);
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Pure combinational word -> control bundle translation.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int OP_W    = 3,
    parameter int REG_AW  = 3,
    parameter int JPTR_W  = 8
) (
    input  logic [INSTR_W-1:0] instr,
    output ctrl_t              ctrl
);

    assign ctrl = decode(MAX_IW'(instr), INSTR_W, OP_W, REG_AW, JPTR_W);

endmodule

// File: rtl/ctrl_pipe.sv
// Registered decoder stage: handshake, load-use stall, branch squash
// and sticky halt between fetch and execute.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int INSTR_W  = 9,
    parameter int OP_W     = 3,
    parameter int REG_AW   = 3,
    parameter int JPTR_W   = 8,
    parameter int LOAD_LAT = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [JPTR_W-1:0]  Jptr,
    output logic [OP_W-1:0]    Aluop,
    output logic [REG_AW-1:0]  Ra,
    output logic [REG_AW-1:0]  Rb,
    output logic [REG_AW-1:0]  Wd,
    output logic               WenR,
    output logic               WenD,
    output logic               RenD,
    output logic               MemToReg,
    output logic               Jen,
    output logic               Done
);

    state_e              state;
    logic [2:0]          cnt;
    logic                ld_v;
    logic [REG_AW-1:0]   ld_wd;
    ctrl_t               dec;
    ctrl_t               out_q;
    logic                reads;
    logic                hazard;
    logic                unused_bits;

    ctrl_decode #(
        .INSTR_W(INSTR_W),
        .OP_W   (OP_W),
        .REG_AW (REG_AW),
        .JPTR_W (JPTR_W)
    ) u_dec (
        .instr(instr),
        .ctrl (dec)
    );

    assign reads = (dec.cls == CL_R) || (dec.cls == CL_ST)
                || (dec.cls == CL_MV);

    assign hazard = instr_valid && ld_v && reads
                 && ((dec.ra[REG_AW-1:0] == ld_wd)
                  || (dec.rb[REG_AW-1:0] == ld_wd));

    assign instr_ready = !Reset
                      && ((state == SQUASH) || ((state == RUN) && !hazard));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RUN;
            cnt   <= '0;
            ld_v  <= 1'b0;
            ld_wd <= '0;
            out_q <= '0;
        end else begin
            out_q <= '0;
            unique case (state)
                RUN: begin
                    if (instr_valid) begin
                        if (hazard) begin
                            // the refused cycle is itself the first stall cycle
                            ld_v  <= 1'b0;
                            cnt   <= 3'(LOAD_LAT - 1);
                            state <= (LOAD_LAT > 1) ? STALL : RUN;
                        end else begin
                            out_q <= dec;
                            ld_v  <= (dec.cls == CL_LD);
                            ld_wd <= dec.wd[REG_AW-1:0];
                            if (dec.cls == CL_BR)
                                state <= SQUASH;
                            else if (dec.cls == CL_HALT)
                                state <= HALT;
                        end
                    end
                end
                STALL: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= RUN;
                end
                SQUASH: begin
                    if (instr_valid)
                        state <= RUN;
                end
                HALT: begin
                    out_q.done <= 1'b1;
                end
            endcase
        end
    end

    assign Jptr     = out_q.jptr[JPTR_W-1:0];
    assign Aluop    = out_q.aluop[OP_W-1:0];
    assign Ra       = out_q.ra[REG_AW-1:0];
    assign Rb       = out_q.rb[REG_AW-1:0];
    assign Wd       = out_q.wd[REG_AW-1:0];
    assign WenR     = out_q.wen_r;
    assign WenD     = out_q.wen_d;
    assign RenD     = out_q.ren_d;
    assign MemToReg = out_q.mem_to_reg;
    assign Jen      = out_q.jen;
    assign Done     = out_q.done;

    assign unused_bits = ^{out_q, dec};

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe at LOAD_LAT 1 and 3: directed literal checks plus
// randomized traffic against a cycle-level behavioural model.
module tb_ctrl_pipe;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] jptr;
        logic [2:0] aluop;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] wd;
        logic       wenr;
        logic       wend;
        logic       rend;
        logic       m2r;
        logic       jen;
        logic       done;
    } exp_t;

    // k: 0 R, 1 halt, 2 branch, 3 store, 4 load, 5 move
    function automatic exp_t mdec(input logic [8:0] x, output int k);
        exp_t e;
        e = '0;
        k = 0;
        if (x == 9'h0FF) begin
            k = 1;
            e.done = 1'b1;
        end else if (!x[8]) begin
            e.aluop = x[7:5];
            e.ra    = {1'b0, x[4:3]};
            e.rb    = x[2:0];
            e.wd    = x[2:0];
            e.wenr  = 1'b1;
        end else begin
            case (x[7:6])
                2'b00: begin
                    k = 2;
                    e.jen  = 1'b1;
                    e.jptr = {2'b00, x[5:0]};
                end
                2'b01: begin
                    k = 3;
                    e.wend = 1'b1;
                    e.ra   = 3'd7;
                    e.rb   = x[5:3];
                end
                2'b10: begin
                    k = 4;
                    e.rend = 1'b1;
                    e.m2r  = 1'b1;
                    e.wenr = 1'b1;
                    e.wd   = x[5:3];
                    e.ra   = 3'd6;
                end
                default: begin
                    k = 5;
                    e.aluop = 3'd7;
                    e.m2r   = 1'b1;
                    e.wenr  = 1'b1;
                    e.ra    = x[5:3];
                    e.wd    = x[2:0];
                end
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int lat, input int got,
                       input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL lat%0d %s: got %0h expected %0h", lat, nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : blk
        localparam int LAT = (g == 0) ? 1 : 3;

        logic       rst = 1'b1;
        logic       v   = 1'b0;
        logic [8:0] w   = '0;
        logic       rdy;
        logic [7:0] jptr;
        logic [2:0] aluop, ra, rb, wd;
        logic       wenr, wend, rend, m2r, jen, done;
        logic [25:0] got;
        bit         fin = 1'b0;

        ctrl_pipe #(.LOAD_LAT(LAT)) dut (
            .Clk        (clk),
            .Reset      (rst),
            .instr      (w),
            .instr_valid(v),
            .instr_ready(rdy),
            .Jptr       (jptr),
            .Aluop      (aluop),
            .Ra         (ra),
            .Rb         (rb),
            .Wd         (wd),
            .WenR       (wenr),
            .WenD       (wend),
            .RenD       (rend),
            .MemToReg   (m2r),
            .Jen        (jen),
            .Done       (done)
        );

        assign got = {jptr, aluop, ra, rb, wd, wenr, wend, rend, m2r, jen, done};

        // model state: halted, squash pending, stall cycles left, last load
        bit       known = 1'b0;
        bit       halted, squash, llv;
        int       stall;
        logic [2:0] llwd;
        exp_t     expq;

        always @(negedge clk) begin
            exp_t e;
            exp_t nxt;
            int   k;
            logic hz, er;
            e  = mdec(w, k);
            hz = llv && (k == 0 || k == 3 || k == 5)
              && (e.ra == llwd || e.rb == llwd);
            if (rst)                     er = 1'b0;
            else if (halted || stall > 0) er = 1'b0;
            else if (squash)             er = 1'b1;
            else                         er = !(v && hz);
            if (known || rst) chk("ready", LAT, int'(rdy), int'(er));
            if (known) chk("outputs", LAT, int'(got), int'(expq));
            nxt = '0;
            if (rst) begin
                known = 1'b1; halted = 1'b0; squash = 1'b0;
                llv = 1'b0; stall = 0;
            end else if (halted) begin
                nxt.done = 1'b1;
            end else if (stall > 0) begin
                stall--;
            end else if (squash) begin
                if (v) squash = 1'b0;
            end else if (v && hz) begin
                llv = 1'b0;
                stall = LAT - 1;
            end else if (v) begin
                nxt    = e;
                llv    = (k == 4);
                llwd   = e.wd;
                squash = (k == 2);
                halted = (k == 1);
            end
            expq = nxt;
        end

        task automatic put(input logic r, input logic vv, input logic [8:0] ww);
            @(posedge clk);
            #1;
            rst = r;
            v   = vv;
            w   = ww;
            #1;
        endtask

        initial begin
            int n;
            bit hold;
            put(1, 0, 0);
            put(1, 0, 0);
            // reset arriving while a load-use stall is in progress
            put(0, 1, 9'h190);
            put(0, 1, 9'h013);
            chk("hazard_ready", LAT, int'(rdy), 0);
            put(1, 1, 9'h013);
            chk("rst_ready", LAT, int'(rdy), 0);
            put(1, 1, 9'h013);
            put(0, 0, 0);
            chk("post_rst_ready", LAT, int'(rdy), 1);
            chk("post_rst_out", LAT, int'(got), 0);
            chk("post_rst_done", LAT, int'(done), 0);
            // plain R-type
            put(0, 1, 9'h013);
            put(0, 0, 0);
            chk("r_aluop", LAT, int'(aluop), 0);
            chk("r_ra", LAT, int'(ra), 2);
            chk("r_rb", LAT, int'(rb), 3);
            chk("r_wd", LAT, int'(wd), 3);
            chk("r_wenr", LAT, int'(wenr), 1);
            chk("r_others", LAT, int'({wend, rend, m2r, jen, done}), 0);
            // load then dependent R-type
            put(0, 1, 9'h190);
            put(0, 1, 9'h013);
            chk("ld_rend", LAT, int'(rend), 1);
            chk("ld_wd", LAT, int'(wd), 2);
            chk("ld_ra", LAT, int'(ra), 6);
            chk("lu_ready", LAT, int'(rdy), 0);
            n = 0;
            while (!rdy && n < 20) begin
                n++;
                put(0, 1, 9'h013);
                chk("lu_bubble", LAT, int'(got), 0);
            end
            chk("lu_stall_len", LAT, n, LAT);
            put(0, 0, 0);
            chk("lu_issue_wenr", LAT, int'(wenr), 1);
            chk("lu_issue_ra", LAT, int'(ra), 2);
            // branch and its shadow
            put(0, 1, 9'h105);
            put(0, 1, 9'h013);
            chk("br_jen", LAT, int'(jen), 1);
            chk("br_jptr", LAT, int'(jptr), 5);
            chk("br_wenr", LAT, int'(wenr), 0);
            chk("sq_ready", LAT, int'(rdy), 1);
            put(0, 1, 9'h02A);
            chk("sq_bubble", LAT, int'(got), 0);
            put(0, 0, 0);
            chk("after_sq_aluop", LAT, int'(aluop), 1);
            chk("after_sq_ra", LAT, int'(ra), 1);
            chk("after_sq_rb", LAT, int'(rb), 2);
            chk("after_sq_wenr", LAT, int'(wenr), 1);
            // store data hazard on Rb
            put(0, 1, 9'h1A0);
            put(0, 1, 9'h160);
            chk("ld2_wd", LAT, int'(wd), 4);
            chk("st_hz_ready", LAT, int'(rdy), 0);
            n = 0;
            while (!rdy && n < 20) begin
                n++;
                put(0, 1, 9'h160);
            end
            chk("st_stall_len", LAT, n, LAT);
            put(0, 0, 0);
            chk("st_wend", LAT, int'(wend), 1);
            chk("st_ra", LAT, int'(ra), 7);
            chk("st_rb", LAT, int'(rb), 4);
            chk("st_wenr", LAT, int'(wenr), 0);
            // sticky halt
            put(0, 1, 9'h0FF);
            put(0, 1, 9'h013);
            chk("halt_done", LAT, int'(done), 1);
            chk("halt_wenr", LAT, int'(wenr), 0);
            chk("halt_ready", LAT, int'(rdy), 0);
            for (int i = 0; i < 3; i++) begin
                put(0, 1, 9'h013);
                chk("halt_hold_done", LAT, int'(done), 1);
                chk("halt_hold_ready", LAT, int'(rdy), 0);
            end
            put(1, 0, 0);
            put(0, 0, 0);
            chk("halt_rst_done", LAT, int'(done), 0);
            chk("halt_rst_ready", LAT, int'(rdy), 1);
            // randomized traffic; fetch re-presents a refused word
            hold = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                logic       r, nv;
                logic [8:0] nw;
                r = ($urandom_range(0, 59) == 0);
                if (hold && !r) begin
                    nv = 1'b1;
                    nw = w;
                end else begin
                    nv = ($urandom_range(0, 3) != 0);
                    nw = 9'($urandom_range(0, 511));
                    if ($urandom_range(0, 2) == 0) nw[8:6] = 3'b110;
                    if ($urandom_range(0, 99) == 0) nw = 9'h0FF;
                end
                put(r, nv, nw);
                hold = nv && !rdy;
            end
            put(0, 0, 0);
            fin = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(blk[0].fin && blk[1].fin) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk("finished_in_time", 0, int'(blk[0].fin && blk[1].fin), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
